// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin whole-transaction sharing of one i2c_controller with hold watchdog
module i2c_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int HOLD_TIMEOUT = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  output logic [NUM_REQ-1:0]     gnt,
  input  logic [2*NUM_REQ-1:0]   rq_cmd,
  input  logic [NUM_REQ-1:0]     rq_start,
  input  logic [8*NUM_REQ-1:0]   rq_wdata,
  input  logic [NUM_REQ-1:0]     rq_wack,
  output logic [NUM_REQ-1:0]     rq_ready,
  output logic [NUM_REQ-1:0]     rq_rdata_valid,
  output logic [7:0]             rdata,
  output logic [NUM_REQ-1:0]     timeout,
  output logic [1:0]             i2c_cmd,
  output logic                   i2c_start,
  output logic [7:0]             i2c_wdata,
  output logic                   i2c_wack,
  input  logic                   i2c_ready,
  input  logic [7:0]             i2c_rdata,
  input  logic                   i2c_rdata_valid
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int HW = $clog2(HOLD_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, OWNED, FSTOP, DRAIN} state_t;
  state_t state, state_n;
  logic [OW-1:0] owner, owner_n, rr_ptr, pick;
  logic [OW:0] sum;
  logic [2*NUM_REQ-1:0] rr2;
  logic [HW-1:0] hold_ctr;
  logic in_txn, o_start, o_req, o_wack, fwd, idle_c, at_max, fire;
  logic [1:0] o_cmd;
  logic [7:0] o_wdata;
  logic [NUM_REQ-1:0] own_oh;

  function automatic logic [NUM_REQ-1:0] oh(input logic [OW-1:0] k);
    oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << k;
  endfunction

  assign o_cmd   = 2'(rq_cmd >> (2 * owner));
  assign o_wdata = 8'(rq_wdata >> (8 * owner));
  assign o_start = 1'(rq_start >> owner);
  assign o_wack  = 1'(rq_wack >> owner);
  assign o_req   = 1'(req >> owner);
  assign own_oh  = oh(owner);
  assign fwd     = (state == OWNED) & o_start & i2c_ready;
  assign idle_c  = (state == OWNED) & i2c_ready & ~o_start;
  assign at_max  = hold_ctr == HW'(HOLD_TIMEOUT - 1);
  assign fire    = idle_c & o_req & at_max;

  // first set request at or after rr_ptr, wrapping
  always_comb begin
    rr2 = {req, req} >> rr_ptr;
    sum = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (rr2[i]) sum = {1'b0, rr_ptr} + (OW+1)'(i);
    pick = (sum >= (OW+1)'(NUM_REQ)) ? OW'(sum - (OW+1)'(NUM_REQ)) : sum[OW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      in_txn   <= 1'b0;
      hold_ctr <= '0;
      gnt      <= '0;
      timeout  <= '0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      gnt      <= (state_n == IDLE) ? '0 : oh(owner_n);
      timeout  <= fire ? own_oh : '0;
      in_txn   <= (i2c_start && i2c_cmd == 2'd3) ? 1'b0 : (i2c_start && i2c_cmd == 2'd0) ? 1'b1 : in_txn;
      hold_ctr <= idle_c ? (at_max ? hold_ctr : hold_ctr + HW'(1)) : '0;
      if (state_n == IDLE && state != IDLE) rr_ptr <= (owner == OW'(NUM_REQ - 1)) ? '0 : owner + OW'(1);
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    unique case (state)
      IDLE:  if (|req) begin
        state_n = OWNED;
        owner_n = pick;
      end
      OWNED: if (fwd && o_cmd == 2'd3) state_n = DRAIN;
             else if (idle_c && (!o_req || at_max)) state_n = in_txn ? FSTOP : IDLE;
      FSTOP: if (i2c_ready) state_n = DRAIN;
      DRAIN: if (i2c_ready) state_n = IDLE;
    endcase
  end

  always_comb begin
    i2c_cmd        = (state == FSTOP) ? 2'd3 : o_cmd;
    i2c_start      = (fwd | (state == FSTOP)) & i2c_ready;
    i2c_wdata      = o_wdata;
    i2c_wack       = o_wack;
    rq_ready       = (state == OWNED && i2c_ready) ? own_oh : '0;
    rq_rdata_valid = (state != IDLE && i2c_rdata_valid) ? own_oh : '0;
    rdata          = i2c_rdata;
  end
endmodule
